// File: rtl/fetch_boot_stage.sv
// fetch_boot_stage: instruction fetch with on-chip memory, word-stream loader and redirect/stall handling
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   load_en                   1 = loader mode (core held), 0 = run
//   ld_valid, ld_data         loader word stream; ld_ready accepts, ld_count counts words since entering load
//   PC_targetE, PC_srcE       redirect from execute
//   stallF, stallD, flushD    hazard-unit controls
//   instrD, PCD, PCp4D        decode-stage instruction and its PC / PC+4
//   validD, errD              real fetched instruction / replaced due to bad PC
module fetch_boot_stage #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic                  ld_valid,
    input  logic [31:0]           ld_data,
    output logic                  ld_ready,
    output logic [ADDR_WIDTH:0]   ld_count,
    input  logic [31:0]           PC_targetE,
    input  logic                  PC_srcE,
    input  logic                  stallF,
    input  logic                  stallD,
    input  logic                  flushD,
    output logic [31:0]           instrD,
    output logic [31:0]           PCD,
    output logic [31:0]           PCp4D,
    output logic                  validD,
    output logic                  errD
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    typedef enum logic [1:0] {LOAD, PRIME, RUN} state_t;
    state_t state, state_nx;
    logic [31:0] mem [DEPTH];
    logic [31:0] pcf, pcf_new, rdata;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic wr_en, fault, bubble;
    always_comb begin
        state_nx = load_en ? LOAD : (state == LOAD ? PRIME : RUN);
        ld_ready = !rst && state == LOAD && !ld_count[ADDR_WIDTH];
        wr_en    = ld_valid && ld_ready;
        pcf_new  = PC_srcE ? PC_targetE : pcf + 32'd4;
        // reading the upcoming PC one cycle early keeps rdata == mem[pcf] in every RUN cycle
        rd_idx   = (state == RUN && !stallF) ? pcf_new[ADDR_WIDTH+1:2] : pcf[ADDR_WIDTH+1:2];
        fault    = pcf[1:0] != 2'b00 || (pcf >> (ADDR_WIDTH + 2)) != 32'd0;
        bubble   = flushD || state != RUN || load_en;
    end
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[ld_count[ADDR_WIDTH-1:0]] <= ld_data;
        rdata <= mem[rd_idx];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= load_en ? LOAD : PRIME;
            ld_count <= '0;
            pcf      <= RESET_PC;
        end else begin
            state    <= state_nx;
            ld_count <= (state_nx == LOAD && state != LOAD) ? '0 : ld_count + {{ADDR_WIDTH{1'b0}}, wr_en};
            pcf      <= (state_nx == LOAD || state == LOAD) ? RESET_PC :
                        (state == RUN && !stallF) ? pcf_new : pcf;
        end
    end
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            instrD <= NOP_INSTR;
            PCD    <= '0;
            PCp4D  <= '0;
            validD <= 1'b0;
            errD   <= 1'b0;
        end else if (!stallD) begin
            instrD <= fault ? NOP_INSTR : rdata;
            PCD    <= pcf;
            PCp4D  <= pcf + 32'd4;
            validD <= 1'b1;
            errD   <= fault;
        end
    end
endmodule

// File: doc/fetch_boot_stage.md
# fetch_boot_stage

Parametrised instruction-fetch stage with on-chip instruction memory, a built-in program loader and a correct redirect/stall path. It feeds the IF/ID pipeline register to decode. A word-stream loader (fed by the UART receiver) fills memory while the core is held. Fetch then starts at a configurable reset vector, and synchronous-read latency is hidden under branch redirects, stalls and flushes.

## Interface
- ADDR_WIDTH, 8, word-address bits; memory depth = 2^ADDR_WIDTH words
- RESET_PC, 32'h0000_0000, first fetch address after load/reset
- NOP_INSTR, 32'h0000_0013, instruction injected on flush/bubble/error
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- load_en  in  1  level; 1 = loader mode (core held), 0 = run
- ld_valid  in  1  loader word valid
- ld_data  in  32  loader word
- ld_ready  out  1  loader accepts word this cycle
- ld_count  out  ADDR_WIDTH+1  words written since entering LOAD
- PC_targetE  in  32  redirect target from execute
- PC_srcE  in  1  take redirect
- stallF, stallD, flushD  in  1 each  hazard-unit controls
- instrD  out  32  instruction to decode
- PCD, PCp4D  out  32 each  PC and PC+4 of instrD
- validD  out  1  instrD is a real fetched instruction
- errD  out  1  instrD replaced because PC was misaligned or out of range

## Operation
- Memory: internal array, 2^ADDR_WIDTH x 32, one write port (loader), one synchronous read port (1-cycle latency); word index = addr[ADDR_WIDTH+1:2].
- FSM states LOAD, PRIME, RUN.
  - After rst: LOAD if load_en=1, else PRIME.
  - LOAD: ld_ready = (ld_count < 2^ADDR_WIDTH). Each ld_valid & ld_ready writes mem[ld_count] and increments ld_count. Full leaves ld_ready=0; extra words are dropped (handshake never completes). load_en=0 -> PRIME.
  - PRIME: read address = PCF (= RESET_PC); PCF held; decode register held at bubble. Next state is RUN, or LOAD if load_en=1.
  - RUN: normal fetch. load_en=1 -> LOAD with ld_count=0, PCF=RESET_PC, decode register forced to bubble.
- Next PC: PCF_new = PC_srcE ? PC_targetE : PCF+4. PCF updates to PCF_new unless stallF=1 (PC_srcE with stallF=1: stall wins; hazard unit must not assert both).
- Read address in RUN = stallF ? PCF : PCF_new. The read-data output in any RUN cycle therefore equals mem[PCF]. This is the invariant the verifier checks.
- Fault: PCF[1:0]!=0 or PCF[31:ADDR_WIDTH+2]!=0. The fetched instruction is replaced by NOP_INSTR and errD=1 travels with it.
- Decode register, in priority order:
  - rst, flushD, or state!=RUN: instrD=NOP_INSTR, PCD=0, PCp4D=0, validD=0, errD=0.
  - Else if stallD: hold all.
  - Else: instrD=mem[PCF] (or NOP on fault), PCD=PCF, PCp4D=PCF+4 (32-bit wrap), validD=1, errD=fault.
- flushD overrides stallD.

## Timing
- Reset values: PCF=RESET_PC, ld_count=0, ld_ready=0 during rst cycle, instrD=NOP_INSTR, PCD=PCp4D=0, validD=errD=0.
- Loader write at edge k is readable by the read port from edge k+1.
- load_en falling edge to first validD=1 is 3 clk edges: LOAD->PRIME, PRIME->RUN, RUN register load.
- Redirect: PC_srcE=1 in cycle n gives instrD = mem[PC_targetE] after edge n+2. The hazard unit flushes D for the wrong-path instruction at edge n+1.
- Stall: instrD/PCD constant while stallD=1. No instruction is lost or duplicated on stall release.
- rst mid-load: ld_count=0; memory contents retained.

## Test plan
- Load 4 words (0x00100093, 0x00200113, 0x00308193, 0x00000013), drop load_en -> PCD sequence 0,4,8,12 with those instrD values. validD=1 first occurs 3 edges after load_en falls.
- ADDR_WIDTH=2: offer 6 words back-to-back -> ld_count stops at 4, ld_ready=0 after the 4th, and mem[0..3] equals the first 4 words.
- RUN at PCF=0x8, PC_srcE=1, PC_targetE=0x0, flushD the following cycle -> one validD=0 bubble, then instrD=mem[0] with PCD=0.
- stallF=stallD=1 for 3 cycles at PCD=0x4 -> outputs frozen. After release, PCD steps 0x8, 0xC with matching words.
- Redirect to 0x6, then to 0x400 with ADDR_WIDTH=8 -> instrD=0x00000013, errD=1, validD=1 for each.
- Assert load_en in RUN and stream 2 new words -> decode register at bubble immediately. After load_en drops, fetch restarts at RESET_PC with the new words.
